// File: rtl/rejestr_wyjsc_pkg.sv
`default_nettype none
//==============================================================================
// Module      : rejestr_wyjsc_pkg
// Description : Shared types and constants for the PLC output image register.
//               The optional bit-write feature is enabled by defining
//               REJESTR_WYJSC_BIT_EN.
// Revision    : 1.0 - initial release
//==============================================================================
package rejestr_wyjsc_pkg;

   // Number of physical output bytes and the width of a byte address
   localparam int NUM_BYTES = 8;
   localparam int ADDR_W    = 3;

   // Default value driven on the outputs while the scan watchdog has tripped
   localparam logic [7:0] SAFE_VALUE_DEF = 8'h00;

   typedef logic [7:0] byte_t;

   // Two-state control FSM: normal scanning, or watchdog fault
   typedef enum logic {
      ST_RUN   = 1'b0,
      ST_FAULT = 1'b1
   } state_t;

   // Return a byte with one bit replaced
   function automatic byte_t set_bit(input byte_t b, input logic [2:0] pos,
                                     input logic v);
      byte_t r;
      r      = b;
      r[pos] = v;
      return r;
   endfunction

endpackage : rejestr_wyjsc_pkg
`default_nettype wire

// File: rtl/rejestr_wyjsc_if.sv
`default_nettype none
//==============================================================================
// Module      : rejestr_wyjsc_if
// Description : CPU-side write bus and physical output bus of the output image
//               register. Bit-write signals exist only when
//               REJESTR_WYJSC_BIT_EN is defined.
// Revision    : 1.0 - initial release
//==============================================================================
interface rejestr_wyjsc_if;
   import rejestr_wyjsc_pkg::*;

   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [7:0]        wr_data;
   logic              commit;
   logic              fault_clr;
`ifdef REJESTR_WYJSC_BIT_EN
   logic              bit_en;
   logic [ADDR_W+2:0] bit_idx;
   logic              bit_val;
`endif
   logic [7:0]        out0;
   logic [7:0]        out1;
   logic [7:0]        out2;
   logic [7:0]        out3;
   logic [7:0]        out4;
   logic [7:0]        out5;
   logic [7:0]        out6;
   logic [7:0]        out7;
   logic              wd_fault;

   // CPU / scan controller side
   modport master (
      output wr_en, wr_addr, wr_data, commit, fault_clr,
`ifdef REJESTR_WYJSC_BIT_EN
      output bit_en, bit_idx, bit_val,
`endif
      input  out0, out1, out2, out3, out4, out5, out6, out7, wd_fault
   );

   // Output register side
   modport slave (
      input  wr_en, wr_addr, wr_data, commit, fault_clr,
`ifdef REJESTR_WYJSC_BIT_EN
      input  bit_en, bit_idx, bit_val,
`endif
      output out0, out1, out2, out3, out4, out5, out6, out7, wd_fault
   );

endinterface : rejestr_wyjsc_if
`default_nettype wire

// File: rtl/rejestr_wyjsc_wd_licznik.sv
`default_nettype none
//==============================================================================
// Module      : rejestr_wyjsc_wd_licznik
// Description : Saturating scan watchdog counter. Counts enabled cycles up to
//               WD_CYCLES-1 and flags expiry while parked there.
// Revision    : 1.0 - initial release
//==============================================================================
module rejestr_wyjsc_wd_licznik #(
   parameter int WD_CYCLES = 1000000
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam int              CNT_W   = (WD_CYCLES > 2) ? $clog2(WD_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WD_CYCLES - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Next count: clear has priority, otherwise count up and stick at the top
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Counter register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired = (cnt_q == CNT_MAX);

endmodule : rejestr_wyjsc_wd_licznik
`default_nettype wire

// File: rtl/rejestr_wyjsc.sv
`default_nettype none
//==============================================================================
// Module      : rejestr_wyjsc
// Description : PLC output image register. The CPU fills a shadow image during
//               the scan; a commit strobe copies the whole image to the eight
//               registered output bytes at once. A scan watchdog drives the
//               outputs to SAFE_VALUE if commits stop arriving.
//               Optional bit writes: define REJESTR_WYJSC_BIT_EN.
// Revision    : 1.0 - initial release
//==============================================================================
module rejestr_wyjsc
   import rejestr_wyjsc_pkg::*;
#(
   parameter int         WD_CYCLES  = 1000000,
   parameter logic [7:0] SAFE_VALUE = SAFE_VALUE_DEF
) (
   input  logic            clk,
   input  logic            rst,
   rejestr_wyjsc_if.slave  bus
);

   byte_t  shadow_q [NUM_BYTES];
   byte_t  shadow_d [NUM_BYTES];
   byte_t  out_q    [NUM_BYTES];
   state_t state_q;
   logic   wd_fault_q;

   logic   wd_clr;
   logic   wd_en;
   logic   wd_expired;

   // Next shadow image: byte write first, then the bit write overrides one bit
   always_comb begin
      for (int i = 0; i < NUM_BYTES; i++) begin
         shadow_d[i] = shadow_q[i];
      end
      if (bus.wr_en) begin
         shadow_d[bus.wr_addr] = bus.wr_data;
      end
`ifdef REJESTR_WYJSC_BIT_EN
      if (bus.bit_en) begin
         shadow_d[bus.bit_idx[5:3]] = set_bit(shadow_d[bus.bit_idx[5:3]],
                                              bus.bit_idx[2:0], bus.bit_val);
      end
`endif
   end

   // Shadow image register; writes are taken in every state
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_BYTES; i++) begin
            shadow_q[i] <= SAFE_VALUE;
         end
      end else begin
         for (int i = 0; i < NUM_BYTES; i++) begin
            shadow_q[i] <= shadow_d[i];
         end
      end
   end

   // Counter runs only in RUN. It is cleared by a commit, held at zero in FAULT,
   // and also cleared on the expiry edge (that edge either commits or faults).
   assign wd_en  = (state_q == ST_RUN);
   assign wd_clr = (state_q == ST_FAULT) | bus.commit | wd_expired;

   rejestr_wyjsc_wd_licznik #(
      .WD_CYCLES (WD_CYCLES)
   ) u_wd_licznik (
      .clk     (clk),
      .rst     (rst),
      .clr     (wd_clr),
      .en      (wd_en),
      .expired (wd_expired)
   );

   // Control FSM with registered outputs: commit wins over expiry in RUN;
   // in FAULT commits are ignored and only fault_clr returns to RUN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_RUN;
         wd_fault_q <= 1'b0;
         for (int i = 0; i < NUM_BYTES; i++) begin
            out_q[i] <= SAFE_VALUE;
         end
      end else begin
         case (state_q)
            ST_RUN: begin
               if (bus.commit) begin
                  for (int i = 0; i < NUM_BYTES; i++) begin
                     out_q[i] <= shadow_d[i];
                  end
               end else if (wd_expired) begin
                  state_q    <= ST_FAULT;
                  wd_fault_q <= 1'b1;
                  for (int i = 0; i < NUM_BYTES; i++) begin
                     out_q[i] <= SAFE_VALUE;
                  end
               end
            end
            ST_FAULT: begin
               for (int i = 0; i < NUM_BYTES; i++) begin
                  out_q[i] <= SAFE_VALUE;
               end
               if (bus.fault_clr) begin
                  state_q    <= ST_RUN;
                  wd_fault_q <= 1'b0;
               end
            end
            default: begin
               state_q    <= ST_FAULT;
               wd_fault_q <= 1'b1;
            end
         endcase
      end
   end

   assign bus.out0     = out_q[0];
   assign bus.out1     = out_q[1];
   assign bus.out2     = out_q[2];
   assign bus.out3     = out_q[3];
   assign bus.out4     = out_q[4];
   assign bus.out5     = out_q[5];
   assign bus.out6     = out_q[6];
   assign bus.out7     = out_q[7];
   assign bus.wd_fault = wd_fault_q;

endmodule : rejestr_wyjsc
`default_nettype wire

// File: tb/tb_rejestr_wyjsc.sv
`default_nettype none
//==============================================================================
// Module      : tb_rejestr_wyjsc
// Description : Directed self-checking bench for rejestr_wyjsc (WD_CYCLES=16).
//               Bit-write vectors run when REJESTR_WYJSC_BIT_EN is defined.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_rejestr_wyjsc;

   logic clk;
   logic rst;
   int   n_chk;
   int   n_pass;

   rejestr_wyjsc_if bus ();

   rejestr_wyjsc #(
      .WD_CYCLES  (16),
      .SAFE_VALUE (8'h00)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   logic [63:0] outs;
   assign outs = {bus.out7, bus.out6, bus.out5, bus.out4,
                  bus.out3, bus.out2, bus.out1, bus.out0};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Compare one observed value against its expected value
   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp_v);
      n_chk++;
      if (obs === exp_v) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
      end
   endtask

   // Advance one edge and settle just after it
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_chk         = 0;
      n_pass        = 0;
      rst           = 1'b1;
      bus.wr_en     = 1'b0;
      bus.wr_addr   = 3'd0;
      bus.wr_data   = 8'h00;
      bus.commit    = 1'b0;
      bus.fault_clr = 1'b0;
`ifdef REJESTR_WYJSC_BIT_EN
      bus.bit_en    = 1'b0;
      bus.bit_idx   = 6'd0;
      bus.bit_val   = 1'b0;
`endif
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      chk("reset_outs", outs, 64'h0);
      chk("reset_fault", {63'h0, bus.wd_fault}, 64'h0);

      // Shadow writes without commit leave outputs untouched
      bus.wr_en = 1'b1; bus.wr_addr = 3'd2; bus.wr_data = 8'hA5;
      tick();
      bus.wr_addr = 3'd7; bus.wr_data = 8'h3C;
      tick();
      bus.wr_en = 1'b0;
      chk("no_commit_outs", outs, 64'h0);

      // Commit moves the whole image at once
      bus.commit = 1'b1;
      tick();
      bus.commit = 1'b0;
      chk("commit_outs", outs, 64'h3C00000000A50000);

      // Write in the commit cycle is part of the committed image
      bus.wr_en = 1'b1; bus.wr_addr = 3'd0; bus.wr_data = 8'hFF; bus.commit = 1'b1;
      tick();
      bus.wr_en = 1'b0; bus.commit = 1'b0;
      chk("wr_commit_outs", outs, 64'h3C00000000A500FF);

      // Commit on the last allowed cycle keeps RUN
      repeat (15) tick();
      chk("pre_last_fault", {63'h0, bus.wd_fault}, 64'h0);
      bus.commit = 1'b1;
      tick();
      bus.commit = 1'b0;
      chk("last_commit_fault", {63'h0, bus.wd_fault}, 64'h0);
      chk("last_commit_outs", outs, 64'h3C00000000A500FF);

      // Sixteen cycles without commit trip the watchdog
      repeat (15) tick();
      chk("wd15_fault", {63'h0, bus.wd_fault}, 64'h0);
      chk("wd15_outs", outs, 64'h3C00000000A500FF);
      tick();
      chk("wd16_fault", {63'h0, bus.wd_fault}, 64'h1);
      chk("wd16_outs", outs, 64'h0);

      // Writes are accepted in FAULT but commit is ignored
      bus.wr_en = 1'b1; bus.wr_data = 8'h55;
      for (int i = 0; i < 8; i++) begin
         bus.wr_addr = 3'(i);
         tick();
      end
      bus.wr_en = 1'b0;
      bus.commit = 1'b1;
      tick();
      bus.commit = 1'b0;
      chk("fault_commit_outs", outs, 64'h0);
      chk("fault_commit_fault", {63'h0, bus.wd_fault}, 64'h1);

      // fault_clr with commit: clear only
      bus.fault_clr = 1'b1; bus.commit = 1'b1;
      tick();
      bus.fault_clr = 1'b0; bus.commit = 1'b0;
      chk("clr_fault", {63'h0, bus.wd_fault}, 64'h0);
      chk("clr_outs", outs, 64'h0);

      // First commit after recovery
      bus.commit = 1'b1;
      tick();
      bus.commit = 1'b0;
      chk("recover_outs", outs, 64'h5555555555555555);

      // fault_clr in RUN changes nothing
      bus.fault_clr = 1'b1;
      tick();
      bus.fault_clr = 1'b0;
      chk("run_clr_fault", {63'h0, bus.wd_fault}, 64'h0);
      chk("run_clr_outs", outs, 64'h5555555555555555);

`ifdef REJESTR_WYJSC_BIT_EN
      // Byte write then bit override on the same byte
      bus.wr_en = 1'b1; bus.wr_addr = 3'd3; bus.wr_data = 8'h00;
      tick();
      bus.wr_data = 8'h0F;
      bus.bit_en = 1'b1; bus.bit_idx = 6'b011_111; bus.bit_val = 1'b1;
      tick();
      bus.wr_en = 1'b0; bus.bit_en = 1'b0;
      bus.commit = 1'b1;
      tick();
      bus.commit = 1'b0;
      chk("bit_override_outs", outs, 64'h555555558F555555);

      // Bit write in the commit cycle is committed
      bus.bit_en = 1'b1; bus.bit_idx = 6'b000_000; bus.bit_val = 1'b0;
      bus.commit = 1'b1;
      tick();
      bus.bit_en = 1'b0; bus.commit = 1'b0;
      chk("bit_commit_outs", outs, 64'h555555558F555554);
`endif

      // Asynchronous reset mid-cycle clears outputs without an edge
      @(posedge clk);
      #3 rst = 1'b1;
      #1;
      chk("async_rst_outs", outs, 64'h0);
      chk("async_rst_fault", {63'h0, bus.wd_fault}, 64'h0);
      @(posedge clk);
      #1 rst = 1'b0;

      // Shadow was discarded by reset
      bus.commit = 1'b1;
      tick();
      bus.commit = 1'b0;
      chk("post_rst_commit", outs, 64'h0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule : tb_rejestr_wyjsc
`default_nettype wire

// File: doc/rejestr_wyjsc.md
Name: rejestr_wyjsc

Overview:
Output image register for the PLC I/O path, feeding eight 8-bit physical output bytes.
- CPU writes bytes or single bits into a shadow image during the scan.
- A `commit` strobe at end of scan transfers the whole shadow to the physical outputs atomically, so outputs never show a half-updated scan.
- A scan watchdog forces outputs to a safe value if commits stop arriving.

Parameters:
- WD_CYCLES, 1000000: clock cycles allowed between commits before a fault; minimum 2.
- SAFE_VALUE, 8'h00: value driven on every output byte while in FAULT.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- wr_en  in  1  byte write strobe into the shadow image.
- wr_addr  in  3  shadow byte index 0..7.
- wr_data  in  8  byte written to shadow[wr_addr].
- commit  in  1  end-of-scan strobe: shadow → outputs.
- fault_clr  in  1  acknowledge watchdog fault.
- out0..out7  out  8 each  registered physical output bytes.
- wd_fault  out  1  high while in FAULT.
- bit_en  in  1  bit write strobe (present only with REJESTR_WYJSC_BIT_EN).
- bit_idx  in  6  {byte[5:3], bit[2:0]} (present only with REJESTR_WYJSC_BIT_EN).
- bit_val  in  1  value for the addressed bit (present only with REJESTR_WYJSC_BIT_EN).

Behaviour:
- Clock and reset: one clock, clk; reset rst is asynchronous, active-high.
- Reset values:
  - shadow[0..7] = SAFE_VALUE.
  - out0..out7 = SAFE_VALUE.
  - wd_fault = 0; state = RUN; watchdog counter = 0.
- Shadow writes:
  - wr_en writes shadow[wr_addr] on the rising edge.
  - Writes are accepted in both RUN and FAULT.
- Commit in RUN:
  - On commit, outN takes next-shadow, i.e. shadow including any write in the same cycle.
  - Outputs change exactly one edge after commit is sampled.
  - The watchdog counter is cleared on that edge.
- Watchdog counter:
  - Increments every cycle in RUN without commit and saturates at WD_CYCLES-1.
  - When the counter equals WD_CYCLES-1 and commit is low: transition to FAULT on that edge, with all outN = SAFE_VALUE and wd_fault = 1 on the same edge.
  - If commit arrives on the same cycle as the counter reaches WD_CYCLES-1, commit wins: stay in RUN, clear the counter.
- FAULT:
  - commit is ignored and outputs hold SAFE_VALUE.
  - The counter is held at 0.
  - fault_clr → RUN on the next edge with wd_fault = 0. Outputs stay SAFE_VALUE until the first subsequent commit.
  - fault_clr together with commit in FAULT: clear only; that commit is ignored.
- fault_clr in RUN has no effect.
- Asserting rst mid-scan discards the shadow contents and restores reset values immediately, without waiting for a clock edge.
- Two-state FSM: RUN, FAULT. No other states.

Optional Feature:
REJESTR_WYJSC_BIT_EN
- Defined:
  - Adds ports bit_en, bit_idx and bit_val.
  - bit_en sets shadow[bit_idx[5:3]][bit_idx[2:0]] = bit_val.
  - If wr_en and bit_en target the same byte in the same cycle, the byte write is applied first and the bit write overrides the addressed bit.
  - A bit write in the commit cycle is included in the committed value.
- Not defined: the ports are absent and the shadow is byte-write only.

Decomposition:
- Shared package/include rejestr_wyjsc_pkg:
  - State encodings ST_RUN = 1'b0, ST_FAULT = 1'b1.
  - Byte count 8 and address width 3.
  - Default SAFE_VALUE.
- One sub-module, wd_licznik: saturating watchdog counter.
  - Inputs: clk, rst, clr, en.
  - Output: expired.
  - Parameter: WD_CYCLES.

Test Plan:
- Reset: assert rst asynchronously mid-cycle → all outN = 8'h00 and wd_fault = 0 immediately.
- Atomic commit:
  - Write 8'hA5 to addr 2 and 8'h3C to addr 7 with no commit → outputs unchanged.
  - Pulse commit → out2 = 8'hA5 and out7 = 8'h3C one edge later, all together.
- Same-cycle write and commit: wr_en addr 0 = 8'hFF together with commit → out0 = 8'hFF on that edge.
- Watchdog expiry (WD_CYCLES = 16):
  - No commit for 16 cycles → wd_fault = 1 and all outN = 8'h00.
  - A commit on cycle 15 instead keeps RUN.
- Fault recovery:
  - In FAULT, commit with shadow 8'h55 → outputs stay 8'h00.
  - fault_clr → wd_fault = 0, outputs still 8'h00.
  - Next commit → 8'h55.
- With REJESTR_WYJSC_BIT_EN:
  - Shadow byte 3 = 8'h00; in the same cycle, wr_en addr 3 = 8'h0F and bit_en with bit_idx = 6'b011_111, bit_val = 1.
  - Then commit → out3 = 8'h8F.
